// File: rtl/id_operand_stage_if.sv
// Bundle between decode/GRF read, the operand stage and EX.
// The master modport drives the ID-side inputs. The slave modport is the operand stage.
interface id_operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int INSTR_W = 8,
  parameter int T_W     = 2,
  parameter int CNT_W   = 16
) ();
  logic                      stall;
  logic                      clr;
  logic                      valid_in;
  logic [INSTR_W-1:0]        instr_in;
  logic [DATA_W-1:0]         pc_in;
  logic [ADDR_W-1:0]         rs_addr;
  logic [ADDR_W-1:0]         rt_addr;
  logic [DATA_W-1:0]         grf_rd1;
  logic [DATA_W-1:0]         grf_rd2;
  logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_ok;
  logic [T_W-1:0]            tnew_in;
  logic [ADDR_W-1:0]         wr_addr_in;
  logic [DATA_W-1:0]         wr_data_in;

  logic [DATA_W-1:0]         rs_use;
  logic [DATA_W-1:0]         rt_use;
  logic                      stall_id;
  logic                      valid_ex;
  logic [INSTR_W-1:0]        instr_ex;
  logic [DATA_W-1:0]         pc_ex;
  logic [DATA_W-1:0]         rs_data_ex;
  logic [DATA_W-1:0]         rt_data_ex;
  logic [ADDR_W-1:0]         rs_addr_ex;
  logic [ADDR_W-1:0]         rt_addr_ex;
  logic [ADDR_W-1:0]         wr_addr_ex;
  logic [DATA_W-1:0]         wr_data_ex;
  logic [T_W-1:0]            tnew_ex;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          bubble_cnt;

  modport master (
    output stall, clr, valid_in, instr_in, pc_in, rs_addr, rt_addr, grf_rd1, grf_rd2,
           fwd_addr, fwd_data, fwd_ok, tnew_in, wr_addr_in, wr_data_in,
    input  rs_use, rt_use, stall_id, valid_ex, instr_ex, pc_ex, rs_data_ex, rt_data_ex,
           rs_addr_ex, rt_addr_ex, wr_addr_ex, wr_data_ex, tnew_ex, stall_cnt, bubble_cnt
  );

  modport slave (
    input  stall, clr, valid_in, instr_in, pc_in, rs_addr, rt_addr, grf_rd1, grf_rd2,
           fwd_addr, fwd_data, fwd_ok, tnew_in, wr_addr_in, wr_data_in,
    output rs_use, rt_use, stall_id, valid_ex, instr_ex, pc_ex, rs_data_ex, rt_data_ex,
           rs_addr_ex, rt_addr_ex, wr_addr_ex, wr_data_ex, tnew_ex, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-stage operand resolution with prioritised forwarding, plus the ID/EX pipeline register.
// It also keeps saturating stall and forwarding-bubble counters.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int INSTR_W = 8,
  parameter int T_W     = 2,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  id_operand_stage_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [ADDR_W-1:0]  rs_addr;
    logic [ADDR_W-1:0]  rt_addr;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [T_W-1:0]     tnew;
  } idex_t;

  idex_t             idex_q, idex_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [DATA_W-1:0] rs_val_s, rt_val_s;
  logic              rs_rdy_s, rt_rdy_s;
  logic              fwd_wait_s, stall_id_s;

  // Returns {ready, data}. The first matching source wins even when it is not ready.
  // Register 0 is hard-wired to zero and is always ready.
  function automatic logic [DATA_W:0] resolve(
    input logic [ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]         grf,
    input logic [NUM_FWD*ADDR_W-1:0] faddr,
    input logic [NUM_FWD*DATA_W-1:0] fdata,
    input logic [NUM_FWD-1:0]        fok
  );
    logic [DATA_W:0] res;
    logic            hit;
    res = {1'b1, grf};
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && (faddr[i*ADDR_W +: ADDR_W] == addr)) begin
        hit = 1'b1;
        res = {fok[i], fdata[i*DATA_W +: DATA_W]};
      end
    end
    if (addr == '0) begin
      res = {1'b1, {DATA_W{1'b0}}};
    end
    return res;
  endfunction

  // Operand resolution and stall request.
  always_comb begin
    {rs_rdy_s, rs_val_s} = resolve(bus.rs_addr, bus.grf_rd1, bus.fwd_addr, bus.fwd_data, bus.fwd_ok);
    {rt_rdy_s, rt_val_s} = resolve(bus.rt_addr, bus.grf_rd2, bus.fwd_addr, bus.fwd_data, bus.fwd_ok);
    fwd_wait_s = bus.valid_in & ~(rs_rdy_s & rt_rdy_s);
    stall_id_s = bus.stall | fwd_wait_s;
  end

  // ID/EX next state: flush > hold > bubble > load.
  always_comb begin
    idex_d = '0;
    if (bus.clr) begin
      idex_d = '0;
    end else if (bus.stall) begin
      idex_d = idex_q;
    end else if (fwd_wait_s || !bus.valid_in) begin
      idex_d = '0;
    end else begin
      idex_d.valid   = 1'b1;
      idex_d.instr   = bus.instr_in;
      idex_d.pc      = bus.pc_in;
      idex_d.rs_data = rs_val_s;
      idex_d.rt_data = rt_val_s;
      idex_d.rs_addr = bus.rs_addr;
      idex_d.rt_addr = bus.rt_addr;
      idex_d.wr_addr = bus.wr_addr_in;
      idex_d.wr_data = bus.wr_data_in;
      idex_d.tnew    = (bus.tnew_in == '0) ? '0 : bus.tnew_in - {{(T_W-1){1'b0}}, 1'b1};
    end
  end

  // Saturating performance counters. A flush does not touch them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_id_s && bus.valid_in && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (fwd_wait_s && !bus.stall && !bus.clr && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      idex_q       <= idex_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.rs_use     = rs_val_s;
  assign bus.rt_use     = rt_val_s;
  assign bus.stall_id   = stall_id_s;
  assign bus.valid_ex   = idex_q.valid;
  assign bus.instr_ex   = idex_q.instr;
  assign bus.pc_ex      = idex_q.pc;
  assign bus.rs_data_ex = idex_q.rs_data;
  assign bus.rt_data_ex = idex_q.rt_data;
  assign bus.rs_addr_ex = idex_q.rs_addr;
  assign bus.rt_addr_ex = idex_q.rt_addr;
  assign bus.wr_addr_ex = idex_q.wr_addr;
  assign bus.wr_data_ex = idex_q.wr_data;
  assign bus.tnew_ex    = idex_q.tnew;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: a behavioural model queues the expected outputs per cycle.
// A monitor compares them just after each rising edge.
module tb_id_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 2;
  localparam int IW = 8;
  localparam int TW = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_operand_stage_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .INSTR_W(IW), .T_W(TW), .CNT_W(CW)) bus ();

  id_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .INSTR_W(IW), .T_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic reset, stall, clr, valid;
    logic [IW-1:0] instr;
    logic [DW-1:0] pc, rd1, rd2, wrd;
    logic [AW-1:0] rs, rt, wra;
    logic [AW-1:0] faddr [NF];
    logic [DW-1:0] fdata [NF];
    logic          fok   [NF];
    logic [TW-1:0] tnew;
  } stim_t;

  typedef struct {
    logic          chk_comb;
    logic [DW-1:0] rs_use, rt_use;
    logic          stall_id;
    logic          v;
    logic [IW-1:0] instr;
    logic [DW-1:0] pc, rsd, rtd, wrd;
    logic [AW-1:0] rsa, rta, wra;
    logic [TW-1:0] tnew;
    int            sc, bc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference operand lookup: register 0 is zero. Otherwise the first source naming the register wins.
  // If no source names it, the GRF value is used.
  function automatic void lookup(input logic [AW-1:0] a, input logic [DW-1:0] grf, input stim_t s,
                                 output logic [DW-1:0] v, output logic rdy);
    v = grf;
    rdy = 1'b1;
    if (a == 0) begin
      v = 0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (s.faddr[i] != 0 && s.faddr[i] == a) begin
        v = s.fdata[i];
        rdy = s.fok[i];
        return;
      end
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.reset = 0; s.stall = 0; s.clr = 0; s.valid = 0;
    s.instr = 0; s.pc = 0; s.rd1 = 0; s.rd2 = 0; s.wrd = 0;
    s.rs = 0; s.rt = 0; s.wra = 0; s.tnew = 0;
    for (int i = 0; i < NF; i++) begin
      s.faddr[i] = 0; s.fdata[i] = 0; s.fok[i] = 0;
    end
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.reset = ($urandom_range(0, 49) == 0);
    s.stall = ($urandom_range(0, 7) == 0);
    s.clr   = ($urandom_range(0, 15) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.instr = IW'($urandom);
    s.pc = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.wrd = $urandom;
    s.rs = AW'($urandom_range(0, 3)); s.rt = AW'($urandom_range(0, 3));
    s.wra = AW'($urandom); s.tnew = TW'($urandom);
    for (int i = 0; i < NF; i++) begin
      s.faddr[i] = AW'($urandom_range(0, 3));
      s.fdata[i] = $urandom;
      s.fok[i]   = ($urandom_range(0, 3) != 0);
    end
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    logic [DW-1:0] rsv, rtv;
    logic rsr, rtr, fwait, sid;
    @(negedge clk);
    reset = s.reset;
    bus.stall = s.stall; bus.clr = s.clr; bus.valid_in = s.valid;
    bus.instr_in = s.instr; bus.pc_in = s.pc;
    bus.rs_addr = s.rs; bus.rt_addr = s.rt;
    bus.grf_rd1 = s.rd1; bus.grf_rd2 = s.rd2;
    bus.tnew_in = s.tnew; bus.wr_addr_in = s.wra; bus.wr_data_in = s.wrd;
    for (int i = 0; i < NF; i++) begin
      bus.fwd_addr[i*AW +: AW] = s.faddr[i];
      bus.fwd_data[i*DW +: DW] = s.fdata[i];
      bus.fwd_ok[i] = s.fok[i];
    end
    lookup(s.rs, s.rd1, s, rsv, rsr);
    lookup(s.rt, s.rd2, s, rtv, rtr);
    fwait = s.valid && !(rsr && rtr);
    sid = s.stall || fwait;
    if (s.reset) begin
      m.sc = 0;
      m.bc = 0;
    end else begin
      if (sid && s.valid && m.sc < CMAX) m.sc++;
      if (fwait && !s.stall && !s.clr && m.bc < CMAX) m.bc++;
    end
    if (s.reset || s.clr || (!s.stall && (fwait || !s.valid))) begin
      m.v = 0; m.instr = 0; m.pc = 0; m.rsd = 0; m.rtd = 0; m.wrd = 0;
      m.rsa = 0; m.rta = 0; m.wra = 0; m.tnew = 0;
    end else if (!s.stall) begin
      m.v = 1; m.instr = s.instr; m.pc = s.pc; m.rsd = rsv; m.rtd = rtv; m.wrd = s.wrd;
      m.rsa = s.rs; m.rta = s.rt; m.wra = s.wra;
      m.tnew = (s.tnew == 0) ? TW'(0) : TW'(s.tnew - 1);
    end
    e = m;
    e.chk_comb = !s.reset;
    e.rs_use = rsv;
    e.rt_use = rtv;
    e.stall_id = sid;
    q.push_back(e);
  endtask

  // Monitor: the ID/EX register presents a new value each cycle. Pop one expectation per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        if (mon_e.chk_comb) begin
          chk("rs_use", 64'(bus.rs_use), 64'(mon_e.rs_use));
          chk("rt_use", 64'(bus.rt_use), 64'(mon_e.rt_use));
          chk("stall_id", 64'(bus.stall_id), 64'(mon_e.stall_id));
        end
        chk("valid_ex", 64'(bus.valid_ex), 64'(mon_e.v));
        chk("instr_ex", 64'(bus.instr_ex), 64'(mon_e.instr));
        chk("pc_ex", 64'(bus.pc_ex), 64'(mon_e.pc));
        chk("rs_data_ex", 64'(bus.rs_data_ex), 64'(mon_e.rsd));
        chk("rt_data_ex", 64'(bus.rt_data_ex), 64'(mon_e.rtd));
        chk("rs_addr_ex", 64'(bus.rs_addr_ex), 64'(mon_e.rsa));
        chk("rt_addr_ex", 64'(bus.rt_addr_ex), 64'(mon_e.rta));
        chk("wr_addr_ex", 64'(bus.wr_addr_ex), 64'(mon_e.wra));
        chk("wr_data_ex", 64'(bus.wr_data_ex), 64'(mon_e.wrd));
        chk("tnew_ex", 64'(bus.tnew_ex), 64'(mon_e.tnew));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(mon_e.sc));
        chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(mon_e.bc));
      end
    end
  end

  initial begin
    stim_t s;
    int guard;
    s = idle();
    bus.stall = 0; bus.clr = 0; bus.valid_in = 0; bus.instr_in = 0; bus.pc_in = 0;
    bus.rs_addr = 0; bus.rt_addr = 0; bus.grf_rd1 = 0; bus.grf_rd2 = 0;
    bus.fwd_addr = 0; bus.fwd_data = 0; bus.fwd_ok = 0;
    bus.tnew_in = 0; bus.wr_addr_in = 0; bus.wr_data_in = 0;
    m = '{default: 0};

    // Reset for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.reset = 1; drive(s);
    end

    // Priority between forwarding sources.
    s = idle(); s.valid = 1; s.rs = 5; s.rd1 = 32'hC;
    s.faddr[0] = 5; s.fdata[0] = 32'hA; s.fok[0] = 1;
    s.faddr[1] = 5; s.fdata[1] = 32'hB; s.fok[1] = 1;
    drive(s);
    s.faddr[0] = 6; drive(s);
    // Unready youngest match blocks fall-through.
    s.faddr[0] = 5; s.fdata[0] = 32'h1234; s.fok[0] = 0; drive(s);

    // Register zero ignores forwarding.
    s = idle(); s.valid = 1; s.rs = 0; s.faddr[0] = 0; s.fdata[0] = 32'hFF; s.fok[0] = 1;
    drive(s);

    // Hold versus flush.
    s = idle(); s.valid = 1; s.pc = 32'h3000; s.instr = 8'h42; drive(s);
    s.stall = 1; s.pc = 32'h4000; drive(s);
    s.clr = 1; drive(s);

    // Counter saturation and Tnew decrement.
    s = idle(); s.reset = 1; drive(s);
    s = idle(); s.valid = 1; s.stall = 1;
    for (int i = 0; i < 20; i++) drive(s);
    s = idle(); s.valid = 1; s.tnew = 0; drive(s);
    s.tnew = 2; drive(s);
    s.tnew = 3; drive(s);
    s.tnew = 1; drive(s);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) drive(rnd());

    s = idle(); drive(s);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
